// File: rtl/vga_timing_monitor_if.sv
// Signal bundle between a TinyVGA source (or test harness) and vga_timing_monitor.
interface vga_timing_monitor_if #(
  parameter int unsigned CW = 11
) ();
  logic [7:0]    i_vga_in;
  logic [CW-1:0] i_probe_x;
  logic [CW-1:0] i_probe_y;
  logic          i_err_clr;
  logic [CW-1:0] o_h_total;
  logic [CW-1:0] o_h_sync_len;
  logic [CW-1:0] o_v_total;
  logic [CW-1:0] o_v_sync_len;
  logic          o_locked;
  logic          o_frame_done;
  logic [5:0]    o_probe_rgb;
  logic          o_probe_valid;
  logic          o_err_timing;

  modport master (
    output i_vga_in, i_probe_x, i_probe_y, i_err_clr,
    input  o_h_total, o_h_sync_len, o_v_total, o_v_sync_len, o_locked, o_frame_done,
    input  o_probe_rgb, o_probe_valid, o_err_timing
  );

  modport slave (
    input  i_vga_in, i_probe_x, i_probe_y, i_err_clr,
    output o_h_total, o_h_sync_len, o_v_total, o_v_sync_len, o_locked, o_frame_done,
    output o_probe_rgb, o_probe_valid, o_err_timing
  );
endinterface

// File: rtl/vga_timing_monitor.sv
// Recovers VGA sync timing from the TinyVGA PMOD bus, locks onto a stable frame,
// flags geometry deviations and captures the colour at a programmable probe point.
module vga_timing_monitor #(
  parameter int unsigned CW              = 11,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input logic                 clk,
  input logic                 rst_n,
  vga_timing_monitor_if.slave bus
);
  localparam logic [CW-1:0] CntMax  = '1;
  localparam logic [CW-1:0] CntOne  = CW'(1);
  // Reset the input stage to idle syncs so leaving reset never fakes an edge.
  localparam logic [7:0]    VgaIdle = {SYNC_ACTIVE_LOW, 3'b000, SYNC_ACTIVE_LOW, 3'b000};

  typedef enum logic [1:0] {StSearch, StMeasure, StLocked} state_e;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] val);
    return (val == CntMax) ? val : val + CntOne;
  endfunction

  state_e        r_state;
  logic [7:0]    r_vga;
  logic          r_hs_prev, r_vs_prev, r_h_seen, r_frame_started;
  logic [CW-1:0] r_hcnt, r_hs_cnt, r_line_cnt, r_vs_cnt;
  logic [CW-1:0] r_h_total, r_h_sync_len, r_v_total, r_v_sync_len;
  logic          r_locked, r_frame_done, r_probe_valid, r_err;
  logic [5:0]    r_probe_rgb;

  logic          w_hs_act, w_vs_act, w_h_edge, w_v_edge, w_hs_fall, w_vs_fall;
  logic          w_h_check, w_mismatch, w_hit;
  logic [CW-1:0] w_meas_h, w_meas_v;
  logic [5:0]    w_rgb;

  assign w_hs_act  = r_vga[7] ^ SYNC_ACTIVE_LOW;
  assign w_vs_act  = r_vga[3] ^ SYNC_ACTIVE_LOW;
  assign w_h_edge  = w_hs_act & ~r_hs_prev;
  assign w_v_edge  = w_vs_act & ~r_vs_prev;
  assign w_hs_fall = ~w_hs_act & r_hs_prev;
  assign w_vs_fall = ~w_vs_act & r_vs_prev;
  assign w_meas_h  = sat_inc(r_hcnt);
  // A line start coincident with vsync still closes the outgoing frame.
  assign w_meas_v  = w_h_edge ? sat_inc(r_line_cnt) : r_line_cnt;
  assign w_h_check = w_h_edge & r_h_seen;
  assign w_mismatch = (r_state == StLocked) &
                      ((w_h_check & (w_meas_h != r_h_total)) |
                       (w_v_edge & (w_meas_v != r_v_total)));
  assign w_hit = (r_state == StLocked) & (r_hcnt == bus.i_probe_x) &
                 (r_line_cnt == bus.i_probe_y);
  assign w_rgb = {r_vga[0], r_vga[4], r_vga[1], r_vga[5], r_vga[2], r_vga[6]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vga      <= VgaIdle;
      r_hs_prev  <= 1'b0;
      r_vs_prev  <= 1'b0;
      r_h_seen   <= 1'b0;
      r_hcnt     <= '0;
      r_hs_cnt   <= '0;
      r_line_cnt <= '0;
      r_vs_cnt   <= '0;
    end else begin
      r_vga     <= bus.i_vga_in;
      r_hs_prev <= w_hs_act;
      r_vs_prev <= w_vs_act;
      r_hcnt    <= w_h_edge ? '0 : sat_inc(r_hcnt);
      r_hs_cnt  <= w_hs_act ? sat_inc(r_hs_cnt) : '0;
      if (w_h_edge) r_h_seen <= 1'b1;
      if (w_v_edge)      r_line_cnt <= '0;
      else if (w_h_edge) r_line_cnt <= sat_inc(r_line_cnt);
      if (!w_vs_act)     r_vs_cnt <= '0;
      else if (w_v_edge) r_vs_cnt <= w_h_edge ? CntOne : '0;
      else if (w_h_edge) r_vs_cnt <= sat_inc(r_vs_cnt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= StSearch;
      r_frame_started <= 1'b0;
      r_h_total       <= '0;
      r_h_sync_len    <= '0;
      r_v_total       <= '0;
      r_v_sync_len    <= '0;
      r_locked        <= 1'b0;
      r_frame_done    <= 1'b0;
      r_probe_rgb     <= '0;
      r_probe_valid   <= 1'b0;
      r_err           <= 1'b0;
    end else begin
      r_frame_done  <= 1'b0;
      r_probe_valid <= w_hit;
      if (w_hit) r_probe_rgb <= w_rgb;
      if (w_mismatch)         r_err <= 1'b1;
      else if (bus.i_err_clr) r_err <= 1'b0;

      case (r_state)
        StSearch: begin
          if (w_v_edge) begin
            r_state         <= StMeasure;
            r_frame_started <= 1'b1;
          end
        end
        StMeasure: begin
          if (w_h_check) r_h_total    <= w_meas_h;
          if (w_hs_fall) r_h_sync_len <= r_hs_cnt;
          if (w_vs_fall) r_v_sync_len <= r_vs_cnt;
          // A full frame (v_edge to v_edge) must be observed before locking.
          if (w_v_edge) begin
            if (r_frame_started) begin
              r_v_total <= w_meas_v;
              r_locked  <= 1'b1;
              r_state   <= StLocked;
            end else begin
              r_frame_started <= 1'b1;
            end
          end
        end
        StLocked: begin
          if (w_mismatch) begin
            r_locked        <= 1'b0;
            r_state         <= StMeasure;
            r_frame_started <= w_v_edge;
            if (w_h_check) r_h_total <= w_meas_h;
            if (w_v_edge)  r_v_total <= w_meas_v;
          end else if (w_v_edge) begin
            r_frame_done <= 1'b1;
          end
        end
        default: r_state <= StSearch;
      endcase
    end
  end

  assign bus.o_h_total     = r_h_total;
  assign bus.o_h_sync_len  = r_h_sync_len;
  assign bus.o_v_total     = r_v_total;
  assign bus.o_v_sync_len  = r_v_sync_len;
  assign bus.o_locked      = r_locked;
  assign bus.o_frame_done  = r_frame_done;
  assign bus.o_probe_rgb   = r_probe_rgb;
  assign bus.o_probe_valid = r_probe_valid;
  assign bus.o_err_timing  = r_err;
endmodule

// File: tb/tb_vga_timing_monitor.sv
// Scoreboard bench for vga_timing_monitor: a scaled-down frame stream drives an active-low
// and an active-high instance in parallel; monitors pop expected pulses from queues.
module tb_vga_timing_monitor;
  localparam int unsigned CW = 11;
  localparam int H = 160, HS = 16, V = 25, VS = 2;
  localparam int PX = 100, PY = 10;
  localparam int NONE = -5;
  localparam logic [5:0] PCol = 6'b110011;
  localparam logic [5:0] Bg   = 6'b001100;

  typedef struct packed {
    logic [CW-1:0] ht;
    logic [CW-1:0] hs;
    logic [CW-1:0] vt;
    logic [CW-1:0] vs;
  } frame_exp_t;

  localparam frame_exp_t ExpGeom = '{CW'(H), CW'(HS), CW'(V), CW'(VS)};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  frame_exp_t q_frame_a[$], q_frame_b[$];
  logic [5:0] q_probe_a[$], q_probe_b[$];

  always #5 clk = ~clk;

  vga_timing_monitor_if #(.CW(CW)) bus_a ();
  vga_timing_monitor_if #(.CW(CW)) bus_b ();

  vga_timing_monitor #(.CW(CW), .SYNC_ACTIVE_LOW(1'b1)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  vga_timing_monitor #(.CW(CW), .SYNC_ACTIVE_LOW(1'b0)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: pulse seen, none expected", name);
  endtask

  task automatic chk_ab(input string name, input longint act_a, input longint act_b,
                        input longint exp);
    check({"A ", name}, act_a, exp);
    check({"B ", name}, act_b, exp);
  endtask

  task automatic chk_reset(input string tag);
    check({tag, " A outputs"}, longint'({bus_a.o_h_total, bus_a.o_h_sync_len, bus_a.o_v_total,
          bus_a.o_v_sync_len, bus_a.o_locked, bus_a.o_frame_done, bus_a.o_probe_rgb,
          bus_a.o_probe_valid, bus_a.o_err_timing}), 0);
    check({tag, " B outputs"}, longint'({bus_b.o_h_total, bus_b.o_h_sync_len, bus_b.o_v_total,
          bus_b.o_v_sync_len, bus_b.o_locked, bus_b.o_frame_done, bus_b.o_probe_rgb,
          bus_b.o_probe_valid, bus_b.o_err_timing}), 0);
  endtask

  task automatic chk_geom(input string tag);
    chk_ab({tag, " h_total"}, bus_a.o_h_total, bus_b.o_h_total, H);
    chk_ab({tag, " h_sync_len"}, bus_a.o_h_sync_len, bus_b.o_h_sync_len, HS);
    chk_ab({tag, " v_total"}, bus_a.o_v_total, bus_b.o_v_total, V);
    chk_ab({tag, " v_sync_len"}, bus_a.o_v_sync_len, bus_b.o_v_sync_len, VS);
  endtask

  // rgb is {R1,R0,G1,G0,B1,B0}; sync pins carry active ^ act_low.
  function automatic logic [7:0] enc(input bit hs, input bit vs, input logic [5:0] rgb,
                                     input bit act_low);
    logic [7:0] p;
    p[0] = rgb[5];
    p[4] = rgb[4];
    p[1] = rgb[3];
    p[5] = rgb[2];
    p[2] = rgb[1];
    p[6] = rgb[0];
    p[7] = hs ^ act_low;
    p[3] = vs ^ act_low;
    return p;
  endfunction

  task automatic drive_px(input bit hs, input bit vs, input logic [5:0] rgb);
    @(negedge clk);
    bus_a.i_vga_in = enc(hs, vs, rgb, 1'b1);
    bus_b.i_vga_in = enc(hs, vs, rgb, 1'b0);
  endtask

  // The counters are registered behind the sample stage, so hcnt==PX lines up with the
  // pixel one clock after column PX; the probe colour is placed there.
  task automatic drive_frame(input int n_lines, input int short_line, input int stall_line,
                             input int rst_line, input int clr_line, input bit push_done,
                             input bit push_probe);
    int len;
    if (push_done) begin
      q_frame_a.push_back(ExpGeom);
      q_frame_b.push_back(ExpGeom);
    end
    if (push_probe) begin
      q_probe_a.push_back(PCol);
      q_probe_b.push_back(PCol);
    end
    for (int ln = 0; ln < n_lines; ln++) begin
      len = (ln == short_line) ? H - 1 : H;
      if (ln == stall_line) begin
        repeat (3000) drive_px(1'b0, 1'b0, Bg);
        chk_ab("err_timing before stalled h_edge", bus_a.o_err_timing, bus_b.o_err_timing, 0);
      end
      if (ln == rst_line) begin
        rst_n = 1'b0;
        #1;
        chk_reset("mid-frame reset");
      end
      for (int c = 0; c < len; c++) begin
        drive_px(c < HS, ln < VS, (ln == PY && c == PX + 1) ? PCol : Bg);
        if (ln == rst_line && c == 3) rst_n = 1'b1;
        if (ln == clr_line && c == 0) begin
          chk_ab("err_timing before clear", bus_a.o_err_timing, bus_b.o_err_timing, 1);
          bus_a.i_err_clr = 1'b1;
          bus_b.i_err_clr = 1'b1;
        end
        if (ln == clr_line && c == 1) begin
          bus_a.i_err_clr = 1'b0;
          bus_b.i_err_clr = 1'b0;
          chk_ab("err_timing after clear", bus_a.o_err_timing, bus_b.o_err_timing, 0);
        end
        if (c == 4 && (ln == short_line + 1 || ln == stall_line)) begin
          chk_ab("err_timing after bad line", bus_a.o_err_timing, bus_b.o_err_timing, 1);
          chk_ab("locked after bad line", bus_a.o_locked, bus_b.o_locked, 0);
          chk_ab("h_total after bad line", bus_a.o_h_total, bus_b.o_h_total,
                 (ln == stall_line) ? 2047 : H - 1);
        end
      end
    end
  endtask

  always @(negedge clk) begin : monitor
    frame_exp_t e;
    if (bus_a.o_frame_done) begin
      if (q_frame_a.size() == 0) unexpected("A frame_done");
      else begin
        e = q_frame_a.pop_front();
        check("A frame_done h_total", bus_a.o_h_total, e.ht);
        check("A frame_done h_sync_len", bus_a.o_h_sync_len, e.hs);
        check("A frame_done v_total", bus_a.o_v_total, e.vt);
        check("A frame_done v_sync_len", bus_a.o_v_sync_len, e.vs);
        check("A frame_done locked", bus_a.o_locked, 1);
      end
    end
    if (bus_b.o_frame_done) begin
      if (q_frame_b.size() == 0) unexpected("B frame_done");
      else begin
        e = q_frame_b.pop_front();
        check("B frame_done h_total", bus_b.o_h_total, e.ht);
        check("B frame_done h_sync_len", bus_b.o_h_sync_len, e.hs);
        check("B frame_done v_total", bus_b.o_v_total, e.vt);
        check("B frame_done v_sync_len", bus_b.o_v_sync_len, e.vs);
        check("B frame_done locked", bus_b.o_locked, 1);
      end
    end
    if (bus_a.o_probe_valid) begin
      if (q_probe_a.size() == 0) unexpected("A probe_valid");
      else check("A probe_rgb", bus_a.o_probe_rgb, q_probe_a.pop_front());
    end
    if (bus_b.o_probe_valid) begin
      if (q_probe_b.size() == 0) unexpected("B probe_valid");
      else check("B probe_rgb", bus_b.o_probe_rgb, q_probe_b.pop_front());
    end
  end

  initial begin
    bus_a.i_probe_x = CW'(PX);
    bus_a.i_probe_y = CW'(PY);
    bus_b.i_probe_x = CW'(PX);
    bus_b.i_probe_y = CW'(PY);
    bus_a.i_err_clr = 1'b0;
    bus_b.i_err_clr = 1'b0;
    bus_a.i_vga_in  = enc(1'b0, 1'b0, Bg, 1'b1);
    bus_b.i_vga_in  = enc(1'b0, 1'b0, Bg, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("power-on reset");
    rst_n = 1'b1;
    repeat (5) drive_px(1'b0, 1'b0, Bg);

    // f1: first v_edge -> measuring; f2: second v_edge -> locked
    drive_frame(V, NONE, NONE, NONE, NONE, 1'b0, 1'b0);
    chk_ab("locked after one v_edge", bus_a.o_locked, bus_b.o_locked, 0);
    drive_frame(V, NONE, NONE, NONE, NONE, 1'b0, 1'b1);
    chk_ab("locked after two v_edges", bus_a.o_locked, bus_b.o_locked, 1);
    chk_geom("lock");
    drive_frame(V, NONE, NONE, NONE, NONE, 1'b1, 1'b1);

    // f4: line 5 is one clock short
    drive_frame(V, 5, NONE, NONE, NONE, 1'b1, 1'b0);
    drive_frame(V, NONE, NONE, NONE, NONE, 1'b0, 1'b0);
    chk_ab("locked one v_edge after error", bus_a.o_locked, bus_b.o_locked, 0);
    drive_frame(V, NONE, NONE, NONE, NONE, 1'b0, 1'b1);
    chk_ab("relocked after two v_edges", bus_a.o_locked, bus_b.o_locked, 1);
    chk_ab("err_timing sticky after relock", bus_a.o_err_timing, bus_b.o_err_timing, 1);
    chk_geom("relock");

    // f7: err_clr on line 1, then hsync missing for 3000 clocks before line 4
    drive_frame(V, NONE, 4, NONE, 1, 1'b1, 1'b0);
    drive_frame(V, NONE, NONE, NONE, NONE, 1'b0, 1'b0);
    drive_frame(V, NONE, NONE, NONE, NONE, 1'b0, 1'b1);
    chk_ab("relocked after stall", bus_a.o_locked, bus_b.o_locked, 1);

    // f10: reset mid-frame on line 12
    drive_frame(V, NONE, NONE, 12, NONE, 1'b1, 1'b1);
    chk_ab("locked after reset", bus_a.o_locked, bus_b.o_locked, 0);
    chk_ab("h_total unmeasured in search", bus_a.o_h_total, bus_b.o_h_total, 0);
    drive_frame(V, NONE, NONE, NONE, NONE, 1'b0, 1'b0);
    chk_ab("locked one v_edge after reset", bus_a.o_locked, bus_b.o_locked, 0);
    drive_frame(V, NONE, NONE, NONE, NONE, 1'b0, 1'b1);
    chk_ab("locked two v_edges after reset", bus_a.o_locked, bus_b.o_locked, 1);
    chk_geom("post-reset lock");
    drive_frame(3, NONE, NONE, NONE, NONE, 1'b1, 1'b0);
    repeat (10) drive_px(1'b0, 1'b0, Bg);

    check("A frame_done pulses missing", q_frame_a.size(), 0);
    check("B frame_done pulses missing", q_frame_b.size(), 0);
    check("A probe_valid pulses missing", q_probe_a.size(), 0);
    check("B probe_valid pulses missing", q_probe_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
